// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned AddrWDefault = 16;
   localparam int unsigned DataWDefault = 16;
   localparam logic [15:0] ResetPc      = 16'h0000;

   typedef enum logic {
      StFetch,
      StDrain
   } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; Depth must be a power of two.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: credit-limited memory requests, response buffering
// for the decoder, and redirect handling that drops stale in-flight responses.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_value,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              ins_valid,
   output logic [DATA_W-1:0] ins_data,
   output logic [ADDR_W-1:0] ins_pc,
   input  logic              ins_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   fetch_state_e             state_q;
   logic                     started_q;
   logic [CntW-1:0]          outstanding_q, drop_cnt_q, drop_cnt_d;
   logic [CntW-1:0]          aq_count, ib_count;
   logic                     aq_empty, ib_empty;
   logic [ADDR_W-1:0]        aq_rdata;
   logic [DATA_W+ADDR_W-1:0] ib_rdata;
   logic                     redirect, accept, resp_push, ins_pop, credit_ok;

   // Redirects before the block has started are ignored so outputs stay quiet.
   assign redirect  = started_q && redirect_valid;
   assign credit_ok = ({1'b0, outstanding_q} + {1'b0, ib_count}) < (CntW + 1)'(DEPTH);

   assign mem_req   = started_q && (state_q == StFetch) && credit_ok && !redirect_valid;
   assign mem_addr  = started_q ? pc_value : '0;
   assign accept    = mem_req && mem_ready;
   assign pc_inc    = accept;
   assign pc_load   = redirect;
   assign pc_target = started_q ? redirect_pc : '0;

   assign resp_push = mem_rvalid && (drop_cnt_q == '0) && !redirect;
   assign ins_valid = !ib_empty;
   assign ins_pop   = ins_valid && ins_ready;
   assign ins_data  = ins_valid ? ib_rdata[DATA_W+ADDR_W-1:ADDR_W] : '0;
   assign ins_pc    = ins_valid ? ib_rdata[ADDR_W-1:0] : '0;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (redirect) begin
         drop_cnt_d = outstanding_q - CntW'(mem_rvalid);
      end else if (mem_rvalid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CntW'(1);
      end
   end

   // Outside a drain drop_cnt is always zero, so it alone selects the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StFetch;
         started_q     <= 1'b0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         started_q     <= 1'b1;
         outstanding_q <= outstanding_q + CntW'(accept) - CntW'(mem_rvalid);
         drop_cnt_q    <= drop_cnt_d;
         state_q       <= (drop_cnt_d != '0) ? StDrain : StFetch;
      end
   end

   sync_fifo #(
      .Width(ADDR_W),
      .Depth(DEPTH)
   ) u_addr_q (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(1'b0),
      .push_i (accept),
      .wdata_i(mem_addr),
      .pop_i  (mem_rvalid),
      .rdata_o(aq_rdata),
      .empty_o(aq_empty),
      .count_o(aq_count)
   );

   sync_fifo #(
      .Width(DATA_W + ADDR_W),
      .Depth(DEPTH)
   ) u_ins_buf (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(redirect),
      .push_i (resp_push),
      .wdata_i({mem_rdata, aq_rdata}),
      .pop_i  (ins_pop),
      .rdata_o(ib_rdata),
      .empty_o(ib_empty),
      .count_o(ib_count)
   );

   a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
      !(mem_rvalid && (aq_empty || (outstanding_q == '0))));
   a_inc_load_excl: assert property (@(posedge clk) disable iff (rst) !(pc_inc && pc_load));
   a_queue_tracks: assert property (@(posedge clk) disable iff (rst)
      aq_count == outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against an epoch-tagged memory/decoder model.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] pc_value, pc_target, mem_addr, ins_pc, redirect_pc;
   logic [DW-1:0] mem_rdata, ins_data;
   logic          pc_inc, pc_load, mem_req, mem_ready, mem_rvalid;
   logic          ins_valid, ins_ready, redirect_valid;

   instr_fetch_unit #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_value      (pc_value),
      .pc_inc        (pc_inc),
      .pc_load       (pc_load),
      .pc_target     (pc_target),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ready     (mem_ready),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .ins_valid     (ins_valid),
      .ins_data      (ins_data),
      .ins_pc        (ins_pc),
      .ins_ready     (ins_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc)
   );

   always #5 clk = ~clk;

   // A request belongs to the epoch current when it was issued; redirects bump the epoch.
   typedef struct {
      logic [AW-1:0] addr;
      int unsigned   epoch;
      int unsigned   due;
   } req_t;

   req_t          memq[$];
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] pc_m;
   int unsigned   epoch_m, cyc, last_due;
   bit            started_m;
   int            n_checks, n_pass;
   int unsigned   p_ready, p_ins, p_redir, lat_min, lat_max;

   function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
      return DW'(a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic do_reset(input int unsigned cycles);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      mem_rvalid     = 1'b0;
      mem_ready      = 1'($urandom);
      ins_ready      = 1'($urandom);
      #1;
      check_eq("rst_ctl", {mem_req, pc_inc, pc_load, ins_valid}, 4'b0000);
      check_eq("rst_addr", {mem_addr, pc_target}, 32'h0);
      check_eq("rst_ins", {ins_data, ins_pc}, 32'h0);
      memq.delete();
      exp_q.delete();
      pc_m      = ResetPc;
      pc_value  = pc_m;
      started_m = 1'b0;
      last_due  = 0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // One cycle: drive at the falling edge, check 1ns later, advance the model.
   task automatic step();
      req_t        r;
      bit          rv, redir, exp_req, acc;
      int unsigned stale, due;
      ins_ready      = ($urandom_range(99) < p_ins);
      mem_ready      = ($urandom_range(99) < p_ready);
      redirect_valid = ($urandom_range(999) < p_redir);
      redirect_pc    = AW'($urandom);
      rv             = (memq.size() > 0) && (memq[0].due <= cyc);
      mem_rvalid     = rv;
      mem_rdata      = rv ? memfn(memq[0].addr) : DW'($urandom);
      pc_value       = pc_m;
      #1;
      redir = started_m && redirect_valid;
      stale = 0;
      foreach (memq[i]) if (memq[i].epoch != epoch_m) stale++;
      exp_req = started_m && !redirect_valid && (stale == 0) &&
                (memq.size() + exp_q.size() < DEPTH);
      acc = exp_req && mem_ready;

      check_eq("mem_req", mem_req, exp_req);
      if (exp_req) check_eq("mem_addr", mem_addr, pc_m);
      check_eq("pc_inc", pc_inc, acc);
      check_eq("pc_load", pc_load, redir);
      if (redir) check_eq("pc_target", pc_target, redirect_pc);
      check_eq("ins_valid", ins_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         check_eq("ins_pc", ins_pc, exp_q[0]);
         check_eq("ins_data", ins_data, memfn(exp_q[0]));
      end

      if (rv) r = memq.pop_front();
      if (redir) begin
         exp_q.delete();
         epoch_m++;
         pc_m = redirect_pc;
      end else begin
         if (ins_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (rv && r.epoch == epoch_m) exp_q.push_back(r.addr);
      end
      if (acc) begin
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         memq.push_back('{addr: pc_m, epoch: epoch_m, due: due});
         pc_m = pc_m + AW'(1);
      end
      started_m = 1'b1;
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      epoch_m  = 0;
      rst      = 1'b1;
      mem_rdata = '0;
      redirect_pc = '0;

      // Streaming, then back-pressure from the decoder, then memory stalls.
      p_ready = 100; p_ins = 100; p_redir = 0; lat_min = 1; lat_max = 1;
      do_reset(2);
      repeat (40) step();
      p_ins = 0;
      repeat (20) step();
      p_ins = 100;
      repeat (20) step();
      p_ready = 30;
      repeat (60) step();

      // Long latency with occasional redirects: exercises draining.
      p_ready = 100; lat_min = 3; lat_max = 3; p_redir = 40;
      repeat (300) step();

      // Everything random.
      p_ready = 70; p_ins = 60; lat_min = 1; lat_max = 5; p_redir = 80;
      repeat (1500) step();

      // Mid-stream reset, then keep going.
      do_reset(3);
      p_ready = 80; p_ins = 50; lat_min = 1; lat_max = 3; p_redir = 60;
      repeat (600) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer side of the program counter. Reads the current PC value, issues in-order instruction reads to memory over a valid/ready request channel, and buffers returned words with their addresses in a small FIFO for the decoder. It drives the PC's increment and load controls: it increments on every accepted request and loads on a branch/jump redirect, discarding stale in-flight responses.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, instruction word width
DEPTH, 4, FIFO entries and maximum requests in flight plus buffered entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_value  input  ADDR_W  current PC output
pc_inc  output  1  PC increment strobe
pc_load  output  1  PC load strobe
pc_target  output  ADDR_W  PC load value
mem_req  output  1  read request valid
mem_addr  output  ADDR_W  read address
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid; responses return in request order, latency >=1
mem_rdata  input  DATA_W  read data
ins_valid  output  1  instruction available to decoder
ins_data  output  DATA_W  instruction word at FIFO head
ins_pc  output  ADDR_W  address of ins_data
ins_ready  input  1  decoder consumes head this cycle
redirect_valid  input  1  branch/jump taken, flush and refetch
redirect_pc  input  ADDR_W  new fetch address

Behaviour:
- Reset (async, active-high): FIFO empty, outstanding=0, drop_cnt=0, started=0, state=FETCH. All outputs 0 while rst=1 and in the first cycle after release. started sets on the first clock edge after release.
- Credit: issue allowed when started && state==FETCH && (outstanding + fifo_count) < DEPTH && !redirect_valid.
- mem_req = issue allowed. mem_addr = pc_value (combinational).
- Request accepted on mem_req && mem_ready: pc_inc=1 that cycle; outstanding++; mem_addr pushed into an address queue of DEPTH entries.
- Response on mem_rvalid: pop the address queue; outstanding--. If drop_cnt>0, discard the response and decrement drop_cnt. Otherwise push {mem_rdata, popped addr} to the FIFO.
- Simultaneous accept and response in one cycle: outstanding is unchanged. The queue pushes and pops in the same cycle.
- Decoder side: ins_valid = FIFO non-empty. ins_data/ins_pc show the head. Pop on ins_valid && ins_ready. Push and pop may occur in the same cycle. First-word latency is memory latency + 1 cycle (registered FIFO write).
- Redirect (redirect_valid=1):
  - Same cycle: pc_load=1, pc_target=redirect_pc, pc_inc=0, mem_req=0. Redirect has priority over issue.
  - Next edge: FIFO flushed; any ins_ready pop in the redirect cycle is ignored.
  - drop_cnt <= outstanding minus 1 if a response was being popped this cycle, else outstanding. It is the count of stale responses still to come.
  - State goes to DRAIN if that value >0, else FETCH.
- States:
  - FETCH: normal operation.
  - DRAIN: no requests issued; stale responses dropped; move to FETCH when drop_cnt reaches 0 (last stale response cycle -> FETCH next edge).
  - A redirect in DRAIN recomputes drop_cnt as above and stays in DRAIN if the result is nonzero.
- Stale responses never reach the FIFO. Address queue entries for stale requests are popped normally.
- Width rules: counters are $clog2(DEPTH)+1 bits. Address queue and FIFO pointers wrap modulo DEPTH. pc_target passes through unchanged.
- Full condition: when outstanding+fifo_count==DEPTH, mem_req=0 until a decoder pop or redirect. A memory response can never find the FIFO full.
- Reset mid-operation: everything clears immediately. Later responses from pre-reset requests are the environment's responsibility; memory is reset together with this block.
- Assertions: mem_rvalid when outstanding==0 is a protocol error. pc_inc and pc_load are never both 1.

Decomposition:
- Shared package fetch_pkg: state enum {FETCH, DRAIN}, default ADDR_W/DATA_W, a reset-PC constant (0).
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH, with flush). Instantiate it twice: address queue (ADDR_W) and instruction buffer (DATA_W+ADDR_W).

Test Plan:
- Reset release, PC=0, mem_ready=1, latency 1, ins_ready=1: mem_req low in the first cycle after release. Then addresses 0,1,2,... are issued with pc_inc each cycle, and ins_pc 0,1,2 appears with the matching data.
- ins_ready=0, DEPTH=4: exactly 4 requests accepted, then mem_req=0 and ins_valid=1 holding ins_pc=0. Raise ins_ready: one new request per pop.
- mem_ready=0 for 3 cycles: mem_req stays 1 with mem_addr stable at pc_value, and pc_inc=0 throughout.
- Latency 3 with 3 outstanding (addresses 4,5,6), redirect to 0x0100: pc_load=1 and pc_target=0x0100 that cycle, state DRAIN with drop_cnt=3. Responses for 4,5,6 are dropped, then fetch resumes at 0x0100. First ins_pc=0x0100.
- Redirect in the same cycle as a response and a decoder pop: drop_cnt=outstanding-1, the FIFO is empty next cycle, and no stale ins_pc is ever presented.
- Assert rst mid-stream with 2 buffered and 2 outstanding: all outputs 0 immediately, ins_valid=0, counters 0. After release, fetching restarts from pc_value.
